// File: rtl/sio_peripheral_if.sv
// Bundled signals between the serial-core bench/device model and the SOD/SID peripheral endpoint.
interface sio_peripheral_if #(
  parameter int unsigned DIV_W = 16
);
  logic             en;
  logic [DIV_W-1:0] divisor;
  logic             SOD;
  logic             SID;
  logic [7:0]       txData;
  logic             txLoad;
  logic             txBusy;
  logic             txDone;
  logic [7:0]       rxData;
  logic             rxValid;
  logic             rxFramerr;

  modport master (
    output en, divisor, SOD, txData, txLoad,
    input  SID, txBusy, txDone, rxData, rxValid, rxFramerr
  );

  modport slave (
    input  en, divisor, SOD, txData, txLoad,
    output SID, txBusy, txDone, rxData, rxValid, rxFramerr
  );
endinterface

// File: rtl/sio_peripheral.sv
// Peripheral end of the SOD/SID serial link: async 8N1 transmitter and receiver,
// bit timing counted in en ticks with a per-frame latched period.
module sio_peripheral #(
  parameter int unsigned DIV_W = 16
) (
  input logic            clk,
  input logic            rst,
  sio_peripheral_if.slave bus
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Divisors below 2 would leave no room for a mid-bit sample
  logic [DIV_W-1:0] p_sel;
  assign p_sel = (bus.divisor < DIV_W'(2)) ? DIV_W'(2) : bus.divisor;

  tx_state_t        tx_state, tx_state_n;
  logic [DIV_W-1:0] tx_p, tx_p_n, tx_cnt, tx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             sid_q, sid_n, busy_q, busy_n, done_q, done_n;
  logic             tx_end;

  rx_state_t        rx_state, rx_state_n;
  logic [DIV_W-1:0] rx_p, rx_p_n, rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n, rx_data_q, rx_data_n;
  logic             valid_q, valid_n, ferr_q, ferr_n;
  logic             sync1, sync2, hist;
  logic             rx_end_full, rx_end_half;

  assign tx_end      = bus.en && (tx_cnt == tx_p - DIV_W'(1));
  assign rx_end_full = bus.en && (rx_cnt == rx_p - DIV_W'(1));
  assign rx_end_half = bus.en && (rx_cnt == (rx_p >> 1) - DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_p      <= '0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      sid_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_state  <= RX_IDLE;
      rx_p      <= '0;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      hist      <= 1'b1;
    end else begin
      tx_state  <= tx_state_n;
      tx_p      <= tx_p_n;
      tx_cnt    <= tx_cnt_n;
      tx_bit    <= tx_bit_n;
      tx_shift  <= tx_shift_n;
      sid_q     <= sid_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      rx_state  <= rx_state_n;
      rx_p      <= rx_p_n;
      rx_cnt    <= rx_cnt_n;
      rx_bit    <= rx_bit_n;
      rx_shift  <= rx_shift_n;
      rx_data_q <= rx_data_n;
      valid_q   <= valid_n;
      ferr_q    <= ferr_n;
      sync1     <= bus.SOD;
      sync2     <= sync1;
      hist      <= sync2;
    end
  end

  // Transmitter: SID is the registered value for the state being entered
  always_comb begin
    tx_state_n = tx_state;
    tx_p_n     = tx_p;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    sid_n      = sid_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
    if (bus.en && tx_state != TX_IDLE) tx_cnt_n = tx_cnt + DIV_W'(1);
    case (tx_state)
      TX_IDLE: if (bus.txLoad) begin
        tx_shift_n = bus.txData;
        tx_p_n     = p_sel;
        tx_cnt_n   = '0;
        tx_state_n = TX_START;
        sid_n      = 1'b0;
        busy_n     = 1'b1;
      end
      TX_START: if (tx_end) begin
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_state_n = TX_DATA;
        sid_n      = tx_shift[0];
      end
      TX_DATA: if (tx_end) begin
        tx_cnt_n = '0;
        if (tx_bit == 3'd7) begin
          tx_state_n = TX_STOP;
          sid_n      = 1'b1;
        end else begin
          tx_bit_n   = tx_bit + 3'd1;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          sid_n      = tx_shift[1];
        end
      end
      TX_STOP: if (tx_end) begin
        tx_cnt_n   = '0;
        tx_state_n = TX_IDLE;
        sid_n      = 1'b1;
        busy_n     = 1'b0;
        done_n     = 1'b1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Receiver: start on a synchronized falling edge, sample mid-bit thereafter
  always_comb begin
    rx_state_n = rx_state;
    rx_p_n     = rx_p;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_data_n  = rx_data_q;
    valid_n    = 1'b0;
    ferr_n     = 1'b0;
    if (bus.en && rx_state != RX_IDLE) rx_cnt_n = rx_cnt + DIV_W'(1);
    case (rx_state)
      RX_IDLE: if (hist && !sync2) begin
        rx_p_n     = p_sel;
        rx_cnt_n   = '0;
        rx_state_n = RX_START;
      end
      RX_START: if (rx_end_half) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = sync2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_end_full) begin
        rx_cnt_n   = '0;
        rx_shift_n = {sync2, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_end_full) begin
        rx_cnt_n   = '0;
        rx_data_n  = rx_shift;
        valid_n    = sync2;
        ferr_n     = !sync2;
        rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign bus.SID       = sid_q;
  assign bus.txBusy    = busy_q;
  assign bus.txDone    = done_q;
  assign bus.rxData    = rx_data_q;
  assign bus.rxValid   = valid_q;
  assign bus.rxFramerr = ferr_q;

endmodule

// File: doc/sio_peripheral.md
# sio_peripheral

Peripheral-side endpoint of the serial port: the device at the far end of the SOD/SID link. It receives asynchronous frames from the serial core's SOD output and transmits asynchronous frames onto the serial core's SID input. It lets a bench or an on-chip device model talk to the serial core at a programmable bit rate, paced by the 1.79 MHz clock-enable pulse.

## Interface
Parameters:
- DIV_W, 16, width of the bit-period divisor.

Ports:
- clk  in  1  system clock (50 MHz); all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  one-clk tick (enp of the 1.79 MHz domain); all bit timing counts en ticks.
- divisor  in  DIV_W  bit period in en ticks; values 0 and 1 act as 2; latched at frame start.
- SOD  in  1  serial data from the serial core (asynchronous to clk).
- SID  out  1  serial data to the serial core; idle high.
- txData  in  8  byte to send.
- txLoad  in  1  one-clk request to send txData.
- txBusy  out  1  high from the cycle after an accepted txLoad through the end of the stop bit.
- txDone  out  1  one-clk pulse at the end of the stop bit.
- rxData  out  8  last received byte.
- rxValid  out  1  one-clk pulse: frame received with a good stop bit.
- rxFramerr  out  1  one-clk pulse: frame received with a stop bit of 0.

## Operation
- Frame format: start (0), 8 data bits LSB first, stop (1). Each bit lasts P = max(divisor, 2) en ticks.
- Transmitter FSM: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - TX_IDLE: SID=1, txBusy=0. txLoad=1 latches txData and P, then goes to TX_START. txLoad does not need en.
  - Each state holds SID for P en ticks, counted by a tick counter loaded at state entry.
  - TX_DATA uses a 3-bit bit index, shifting LSB first. It moves to TX_STOP after bit 7.
  - At the end of TX_STOP: txDone pulses and the FSM returns to TX_IDLE.
  - txLoad while txBusy=1 is ignored; no queueing.
- Receiver FSM: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - SOD passes through a 2-flop synchronizer plus a history flop. A falling edge (history 1, sync 0) in RX_IDLE latches P and enters RX_START.
  - RX_START waits P/2 en ticks (integer floor) and samples the line.
    - Line 1: glitch; return to RX_IDLE with no output.
    - Line 0: enter RX_DATA.
  - RX_DATA samples 8 bits, each P en ticks after the previous sample, into a shift register filled LSB first.
  - RX_STOP samples the line after P en ticks.
    - Line 1: rxValid pulses.
    - Line 0: rxFramerr pulses.
    - In both cases rxData is updated with the shifted byte and the FSM returns to RX_IDLE.
  - Only a falling edge starts a frame. A line held low (break) after a framing error does not retrigger until SOD has gone high and then low again.
- TX and RX are fully independent (full duplex); simultaneous activity is legal.
- divisor changes mid-frame have no effect until the next frame.

## Timing
- Reset values: SID=1, txBusy=0, txDone=0, rxData=8'h00, rxValid=0, rxFramerr=0. Both FSMs go to IDLE, the synchronizer flops go to 1, and all counters go to 0.
- Reset mid-frame aborts immediately; SID returns to 1 asynchronously with rst.
- TX latency: an accepted txLoad at edge N puts SID=0 and txBusy=1 after edge N+1.
- Bit boundaries: SID changes one clk after the en tick that completes the bit's P-th count.
- Total TX frame length: 10·P en ticks. txDone and the drop of txBusy occur on the same edge that sets SID=1 for idle.
- A txLoad in the txDone cycle is accepted, giving back-to-back frames with no idle gap.
- RX latency: 2–3 clk of synchronizer delay. rxData, rxValid and rxFramerr update on the same edge, the clk after the en tick of the stop-bit sample, about 9.5·P en ticks after the falling edge.
- rxValid and rxFramerr are never high together and are never longer than one clk.
- en high on consecutive clks is legal; each such cycle counts as a tick.

## Test plan
- TX byte: divisor=4, txLoad with txData=8'h61.
  - Required SID: 0,1,0,0,0,0,1,1,0,1, each bit 4 en ticks.
  - txBusy high for 40 en ticks; exactly one txDone pulse.
  - A second txLoad of 8'hFF issued mid-frame is ignored.
- RX good frame: drive SOD with 8'h4B at P=8 (start, 1,1,0,1,0,0,1,0, stop=1).
  - Required: rxData=8'h4B and a single rxValid pulse; rxFramerr stays 0.
- RX framing error: frame 8'hA5 with stop bit 0, then SOD held low for 30 ticks, then high.
  - Required: one rxFramerr pulse and rxData=8'hA5.
  - No further frame starts until SOD rises and falls again.
- Glitch rejection: SOD low for 1 en tick at P=8.
  - Required: no rxValid, no rxFramerr, rxData unchanged.
- Loopback, full duplex:
  - SID tied to SOD, divisor=3, send 8'h00 then 8'hFF back-to-back (second txLoad in the txDone cycle).
  - Required: rxValid twice with rxData 8'h00 then 8'hFF; divisor=0 behaves identically to divisor=2.
- Reset mid-frame: assert rst during TX bit 4 and RX bit 3.
  - Required: SID=1 immediately, all outputs at their reset values, no pulses.
  - A following txLoad of 8'h3C transmits correctly.
